// File: rtl/dfe_chain_ctrl_pkg.sv
// dfe_ctrl_pkg
// Shared definitions for the DFE chain controller slice.
// Contents:
//   ctrl_state_t         controller FSM state encoding (RUN, DRAIN, APPLY, FLUSH)
//   DEF_* constants      default parameter values for N_STAGE, CNT_WIDTH,
//                        QUIET_CYCLES and FLUSH_CYCLES
//   ctr_width()          bit width for a counter that counts 0..max_val-1
package dfe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_t;

  localparam int DEF_N_STAGE      = 5;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_QUIET_CYCLES = 8;
  localparam int DEF_FLUSH_CYCLES = 4;

  // Counters that run 0..max_val-1 need at least one bit even for tiny max_val.
  function automatic int ctr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/dfe_chain_ctrl_if.sv
// dfe_chain_ctrl_if
// Configuration handshake between a configuration master and the chain
// controller.
// Signals:
//   cfg_req      one-cycle configuration request (master -> controller)
//   cfg_bypass   requested per-stage bypass vector
//   cfg_wr_mask  stages whose coefficients are to be written
//   cfg_busy     high from request acceptance until completion
//   cfg_done     one-cycle completion pulse
// Modports: master (requester side), slave (controller side).
interface dfe_chain_ctrl_if
  import dfe_ctrl_pkg::*;
  #(parameter int N_STAGE = DEF_N_STAGE) ();

  logic               cfg_req;
  logic [N_STAGE-1:0] cfg_bypass;
  logic [N_STAGE-1:0] cfg_wr_mask;
  logic               cfg_busy;
  logic               cfg_done;

  modport master (
    output cfg_req, cfg_bypass, cfg_wr_mask,
    input  cfg_busy, cfg_done
  );

  modport slave (
    input  cfg_req, cfg_bypass, cfg_wr_mask,
    output cfg_busy, cfg_done
  );

endinterface

// File: rtl/dfe_chain_ctrl_sat_counter.sv
// sat_counter
// Saturating event counter with synchronous clear.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   inc          count one event this cycle
//   clr          synchronous clear; an event in the same cycle still counts
//   cnt          current count, sticks at all-ones
module sat_counter
  import dfe_ctrl_pkg::*;
  #(parameter int CNT_WIDTH = DEF_CNT_WIDTH) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  // Clear wins over the old value, but a coincident event is counted after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/dfe_chain_ctrl.sv
// dfe_chain_ctrl
// Controls reconfiguration of a DFE filter chain: gates the input strobe
// while the chain is drained, reconfigured and flushed, and keeps sticky
// overflow/underflow status plus saturating event counters.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   valid_in          upstream sample strobe
//   chain_valid_in    strobe to stage 0 (valid_in passed through only in RUN)
//   stage_valid       per-stage valid_out, used to detect a drained chain
//   stage_ovf/unf     per-stage overflow / underflow pulses
//   cfg               configuration handshake (slave side)
//   stage_bypass      registered bypass vector to the stages
//   coeff_wr_en       one-cycle coefficient write strobes
//   clr_status        synchronous clear of flags and counters
//   overflow/underflow sticky status flags
//   ovf_cnt           per-stage overflow counts, stage k at [k*CNT_WIDTH +: CNT_WIDTH]
//   drop_cnt          count of valid_in strobes dropped while held
module dfe_chain_ctrl
  import dfe_ctrl_pkg::*;
  #(
  parameter int N_STAGE      = DEF_N_STAGE,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  output logic                           chain_valid_in,
  input  logic [N_STAGE-1:0]             stage_valid,
  input  logic [N_STAGE-1:0]             stage_ovf,
  input  logic [N_STAGE-1:0]             stage_unf,
  dfe_chain_ctrl_if.slave                cfg,
  output logic [N_STAGE-1:0]             stage_bypass,
  output logic [N_STAGE-1:0]             coeff_wr_en,
  input  logic                           clr_status,
  output logic                           overflow,
  output logic                           underflow,
  output logic [N_STAGE*CNT_WIDTH-1:0]   ovf_cnt,
  output logic [CNT_WIDTH-1:0]           drop_cnt
);

  localparam int QW = ctr_width(QUIET_CYCLES);
  localparam int FW = ctr_width(FLUSH_CYCLES);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [QW-1:0] QONE       = QW'(1);
  localparam logic [FW-1:0] FONE       = FW'(1);

  ctrl_state_t        state;
  logic [QW-1:0]      quiet_cnt;
  logic [FW-1:0]      flush_cnt;
  logic [N_STAGE-1:0] lat_bypass;
  logic [N_STAGE-1:0] lat_mask;
  logic               hold;

  // Any state other than RUN holds off new samples; the state is a register,
  // so the pass-through path is only valid_in AND a flop.
  assign hold           = (state != RUN);
  assign chain_valid_in = valid_in & ~hold;

  // Controller FSM. The bypass and write strobes are loaded on the edge into
  // APPLY so they are visible exactly during the APPLY cycle; cfg_done is
  // raised on the edge back into RUN and dropped again one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      quiet_cnt    <= '0;
      flush_cnt    <= '0;
      lat_bypass   <= '0;
      lat_mask     <= '0;
      stage_bypass <= '0;
      coeff_wr_en  <= '0;
      cfg.cfg_busy <= 1'b0;
      cfg.cfg_done <= 1'b0;
    end else begin
      coeff_wr_en  <= '0;
      cfg.cfg_done <= 1'b0;
      case (state)
        RUN: begin
          if (cfg.cfg_req) begin
            lat_bypass   <= cfg.cfg_bypass;
            lat_mask     <= cfg.cfg_wr_mask;
            quiet_cnt    <= '0;
            cfg.cfg_busy <= 1'b1;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (|stage_valid) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QUIET_LAST) begin
            quiet_cnt    <= '0;
            stage_bypass <= lat_bypass;
            coeff_wr_en  <= lat_mask;
            state        <= APPLY;
          end else begin
            quiet_cnt <= quiet_cnt + QONE;
          end
        end
        APPLY: begin
          flush_cnt <= '0;
          state     <= FLUSH;
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt    <= '0;
            cfg.cfg_busy <= 1'b0;
            cfg.cfg_done <= 1'b1;
            state        <= RUN;
          end else begin
            flush_cnt <= flush_cnt + FONE;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Sticky status flags; a clear coincident with an event leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_status) begin
      overflow  <= |stage_ovf;
      underflow <= |stage_unf;
    end else begin
      overflow  <= overflow  | (|stage_ovf);
      underflow <= underflow | (|stage_unf);
    end
  end

  for (genvar k = 0; k < N_STAGE; k++) begin : g_ovf_cnt
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stage_ovf[k]),
      .clr   (clr_status),
      .cnt   (ovf_cnt[k*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_in & hold),
    .clr   (clr_status),
    .cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_dfe_chain_ctrl.sv
// tb_dfe_chain_ctrl
// Drives two controller instances (16-bit and 4-bit counters) with identical
// stimulus and compares both against a cycle-indexed reference model.
module tb_dfe_chain_ctrl;
  import dfe_ctrl_pkg::*;

  localparam int NS  = 5;
  localparam int QC  = 8;
  localparam int FC  = 4;
  localparam int W16 = 16;
  localparam int W4  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in, cfg_req, clr_status;
  logic [NS-1:0] stage_valid, stage_ovf, stage_unf, cfg_bypass, cfg_wr_mask;

  logic cv16, cv4, ovf16, ovf4, unf16, unf4;
  logic [NS-1:0] byp16, byp4, wr16, wr4;
  logic [NS*W16-1:0] ovfc16;
  logic [NS*W4-1:0]  ovfc4;
  logic [W16-1:0] drop16;
  logic [W4-1:0]  drop4;

  dfe_chain_ctrl_if #(.N_STAGE(NS)) if16 ();
  dfe_chain_ctrl_if #(.N_STAGE(NS)) if4 ();

  assign if16.cfg_req     = cfg_req;
  assign if16.cfg_bypass  = cfg_bypass;
  assign if16.cfg_wr_mask = cfg_wr_mask;
  assign if4.cfg_req      = cfg_req;
  assign if4.cfg_bypass   = cfg_bypass;
  assign if4.cfg_wr_mask  = cfg_wr_mask;

  dfe_chain_ctrl #(.N_STAGE(NS), .CNT_WIDTH(W16), .QUIET_CYCLES(QC), .FLUSH_CYCLES(FC)) dut16 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .chain_valid_in(cv16),
    .stage_valid(stage_valid), .stage_ovf(stage_ovf), .stage_unf(stage_unf),
    .cfg(if16.slave), .stage_bypass(byp16), .coeff_wr_en(wr16),
    .clr_status(clr_status), .overflow(ovf16), .underflow(unf16),
    .ovf_cnt(ovfc16), .drop_cnt(drop16)
  );

  dfe_chain_ctrl #(.N_STAGE(NS), .CNT_WIDTH(W4), .QUIET_CYCLES(QC), .FLUSH_CYCLES(FC)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .chain_valid_in(cv4),
    .stage_valid(stage_valid), .stage_ovf(stage_ovf), .stage_unf(stage_unf),
    .cfg(if4.slave), .stage_bypass(byp4), .coeff_wr_en(wr4),
    .clr_status(clr_status), .overflow(ovf4), .underflow(unf4),
    .ovf_cnt(ovfc4), .drop_cnt(drop4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: cycle index t, configuration timeline in absolute cycles.
  int t = 0;
  bit m_busy, m_done, m_ovf, m_unf;
  int m_last, m_apply;
  logic [NS-1:0] m_lat_byp, m_lat_msk, m_byp, m_wr;
  int m_cnt [NS];
  int m_drop;

  // Observation log for the directed timing checks.
  int wr_pulses = 0;
  int last_wr = -1;
  int last_done = -1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int capped(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    m_busy = 0; m_done = 0; m_ovf = 0; m_unf = 0;
    m_last = 0; m_apply = -1;
    m_lat_byp = '0; m_lat_msk = '0; m_byp = '0; m_wr = '0;
    for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    m_drop = 0;
  endtask

  task automatic checkAll(input logic vin);
    checkOutput("chain_valid16", cv16, vin & !m_busy);
    checkOutput("chain_valid4", cv4, vin & !m_busy);
    checkOutput("cfg_busy", if16.cfg_busy, m_busy);
    checkOutput("cfg_done", if16.cfg_done, m_done);
    checkOutput("stage_bypass", byp16, m_byp);
    checkOutput("coeff_wr_en", wr16, m_wr);
    checkOutput("overflow", ovf16, m_ovf);
    checkOutput("underflow", unf16, m_unf);
    checkOutput("overflow4", ovf4, m_ovf);
    checkOutput("drop_cnt16", drop16, capped(m_drop, W16));
    checkOutput("drop_cnt4", drop4, capped(m_drop, W4));
    for (int k = 0; k < NS; k++) begin
      checkOutput($sformatf("ovf_cnt16[%0d]", k), ovfc16[k*W16 +: W16], capped(m_cnt[k], W16));
      checkOutput($sformatf("ovf_cnt4[%0d]", k), ovfc4[k*W4 +: W4], capped(m_cnt[k], W4));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_chain_valid", cv16, 1'b0);
    checkOutput("rst_busy", if16.cfg_busy, 1'b0);
    checkOutput("rst_done", if16.cfg_done, 1'b0);
    checkOutput("rst_bypass", byp16, '0);
    checkOutput("rst_wr_en", wr16, '0);
    checkOutput("rst_overflow", ovf16, 1'b0);
    checkOutput("rst_underflow", unf16, 1'b0);
    checkOutput("rst_ovf_cnt16", ovfc16, '0);
    checkOutput("rst_ovf_cnt4", ovfc4, '0);
    checkOutput("rst_drop_cnt", drop16, '0);
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, advance model.
  task automatic applyStimulus(input logic vin, input logic [NS-1:0] sv, input logic [NS-1:0] ov,
                               input logic [NS-1:0] un, input logic req, input logic [NS-1:0] byp,
                               input logic [NS-1:0] msk, input logic clr);
    bit held;
    @(posedge clk);
    #1;
    valid_in = vin; stage_valid = sv; stage_ovf = ov; stage_unf = un;
    cfg_req = req; cfg_bypass = byp; cfg_wr_mask = msk; clr_status = clr;
    @(negedge clk);
    checkAll(vin);
    if (|wr16) begin wr_pulses++; last_wr = t; end
    if (if16.cfg_done) last_done = t;

    held = m_busy;
    if (clr) m_drop = int'(held && vin);
    else if (held && vin) m_drop++;
    for (int k = 0; k < NS; k++) m_cnt[k] = clr ? int'(ov[k]) : m_cnt[k] + int'(ov[k]);
    m_ovf = (clr ? 1'b0 : m_ovf) | (|ov);
    m_unf = (clr ? 1'b0 : m_unf) | (|un);

    m_wr = '0;
    m_done = 0;
    if (!m_busy) begin
      if (req) begin
        m_busy = 1; m_last = t; m_apply = -1;
        m_lat_byp = byp; m_lat_msk = msk;
      end
    end else if (m_apply < 0) begin
      if (sv != '0) m_last = t;
      else if (t - m_last == QC) begin
        m_apply = t + 1;
        m_byp = m_lat_byp;
        m_wr = m_lat_msk;
      end
    end else if (t == m_apply + FC) begin
      m_busy = 0;
      m_done = 1;
      m_apply = -1;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Asserts reset between edges, checks the asynchronous response, releases it.
  task automatic doReset();
    valid_in = 0; stage_valid = '0; stage_ovf = '0; stage_unf = '0;
    cfg_req = 0; cfg_bypass = '0; cfg_wr_mask = '0; clr_status = 0;
    #2 rst_n = 1'b0;
    #1 checkResetState();
    modelReset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int c, w0;
    logic [NS-1:0] rsv, rov, run;

    doReset();

    // Pass-through: first cycle after reset release must already follow valid_in.
    for (int i = 0; i < 20; i++)
      applyStimulus((i % 2) == 0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("pass_drop_cnt", drop16, '0);

    // Reconfiguration with a stage_valid pulse three cycles after the request.
    c = t;
    w0 = wr_pulses;
    applyStimulus(1'b1, '0, '0, '0, 1'b1, 5'b00101, 5'b00010, 1'b0);
    for (int i = 1; i < 26; i++)
      applyStimulus(1'b1, (i == 3) ? 5'b00001 : 5'b00000, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("apply_offset", last_wr - c, 12);
    checkOutput("wr_pulse_count", wr_pulses - w0, 1);
    checkOutput("done_offset", last_done - last_wr, FC + 1);
    checkOutput("reconfig_drop_cnt", drop16, 16);
    checkOutput("reconfig_bypass", byp16, 5'b00101);

    // Second request during DRAIN must be ignored.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b01001, 5'b00001, 1'b0);
    applyStimulus(1'b0, 5'b00010, '0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b10110, 5'b11111, 1'b0);
    idle(20);
    checkOutput("ignored_req_bypass", byp16, 5'b01001);

    // Saturation of the 4-bit counters.
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, '0, 5'b00100, '0, 1'b0, '0, '0, 1'b0);
    idle(1);
    checkOutput("sat_cnt4_2", ovfc4[2*W4 +: W4], 4'd15);
    checkOutput("sat_cnt4_0", ovfc4[0 +: W4], 4'd0);
    checkOutput("sat_cnt16_2", ovfc16[2*W16 +: W16], 16'd20);
    checkOutput("sat_overflow4", ovf4, 1'b1);

    // Clear coincident with an underflow event, then a clear on its own.
    applyStimulus(1'b0, '0, '0, 5'b00001, 1'b0, '0, '0, 1'b1);
    idle(1);
    checkOutput("clr_evt_underflow", unf16, 1'b1);
    checkOutput("clr_evt_overflow", ovf16, 1'b0);
    checkOutput("clr_evt_ovf_cnt", ovfc16, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(1);
    checkOutput("clr_alone_underflow", unf16, 1'b0);

    // Reset in the middle of FLUSH abandons the configuration.
    applyStimulus(1'b1, '0, '0, '0, 1'b1, 5'b11000, 5'b10001, 1'b0);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("pre_reset_busy", if16.cfg_busy, 1'b1);
    w0 = wr_pulses;
    c = t;
    doReset();
    applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("post_reset_follow", cv16, 1'b1);
    idle(10);
    checkOutput("post_reset_no_wr", wr_pulses - w0, 0);
    checkOutput("post_reset_no_done", int'(last_done >= c), 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      rsv = ($urandom_range(3) == 0) ? NS'($urandom) : '0;
      rov = ($urandom_range(7) == 0) ? NS'($urandom) : '0;
      run = ($urandom_range(7) == 0) ? NS'($urandom) : '0;
      applyStimulus(1'($urandom), rsv, rov, run, $urandom_range(11) == 0,
                    NS'($urandom), NS'($urandom), $urandom_range(63) == 0);
      if ((i % 500) == 499) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dfe_chain_ctrl.md
DFE_CHAIN_CTRL -- requirements
Module: dfe_chain_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_STAGE, 5, number of filter stages in the chain.
- CNT_WIDTH, 16, width of each event counter.
- QUIET_CYCLES, 8, consecutive cycles with no stage_valid needed to declare the chain drained.
- FLUSH_CYCLES, 4, hold cycles after a configuration change is applied.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- valid_in, in, 1, sample strobe from upstream.
- chain_valid_in, out, 1, gated strobe driven to stage 0.
- stage_valid, in, N_STAGE, valid_out of each stage.
- stage_ovf, in, N_STAGE, per-stage overflow pulse.
- stage_unf, in, N_STAGE, per-stage underflow pulse.
- cfg_req, in, 1, one-cycle configuration request.
- cfg_bypass, in, N_STAGE, requested bypass vector.
- cfg_wr_mask, in, N_STAGE, stages whose coefficients are written.
- cfg_busy, out, 1, high from request acceptance to cfg_done.
- cfg_done, out, 1, one-cycle completion pulse.
- stage_bypass, out, N_STAGE, registered bypass driven to the stages.
- coeff_wr_en, out, N_STAGE, one-cycle coefficient write strobes.
- clr_status, in, 1, synchronous clear of sticky flags and counters.
- overflow, out, 1, sticky OR of all stage_ovf.
- underflow, out, 1, sticky OR of all stage_unf.
- ovf_cnt, out, N_STAGE*CNT_WIDTH, per-stage saturating overflow counts; stage k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- drop_cnt, out, CNT_WIDTH, saturating count of valid_in strobes dropped while held.

Function
REQ-003 The FSM SHALL have states RUN, DRAIN, APPLY and FLUSH.
REQ-004 In RUN, chain_valid_in SHALL equal valid_in combinationally, with zero latency.
REQ-005 In DRAIN, APPLY and FLUSH, hold SHALL be active and chain_valid_in SHALL be 0.
REQ-006 cfg_req in RUN SHALL do all of the following:
- latch cfg_bypass and cfg_wr_mask;
- enter DRAIN on the next cycle;
- set cfg_busy on the same edge.
REQ-007 cfg_req while cfg_busy is high SHALL be ignored and SHALL leave the latched values unchanged.
REQ-008 DRAIN SHALL count consecutive cycles with stage_valid == 0.
- Any nonzero stage_valid SHALL reset the count.
- When the count reaches QUIET_CYCLES, the FSM SHALL go to APPLY.
REQ-009 APPLY SHALL last exactly one cycle.
- stage_bypass SHALL load the latched bypass vector.
- coeff_wr_en SHALL equal the latched mask for that cycle only.
- The FSM SHALL then enter FLUSH.
REQ-010 FLUSH SHALL last FLUSH_CYCLES cycles and then return to RUN.
- On the return edge, cfg_busy SHALL clear and cfg_done SHALL pulse for one cycle.
REQ-011 Drop counting:
- valid_in high while hold is active SHALL increment drop_cnt.
- valid_in in the cycle of cfg_req SHALL pass through, because hold is not yet active.
REQ-012 stage_ovf[k] SHALL increment counter k by 1 per cycle.
- Each counter SHALL saturate at 2^CNT_WIDTH-1 and not wrap.
- drop_cnt SHALL saturate the same way.
REQ-013 Any stage_ovf bit SHALL set overflow, and any stage_unf bit SHALL set underflow.
- Both flags SHALL hold until clr_status or reset.
REQ-014 clr_status SHALL zero all counters and flags on the next edge.
- An event in the same cycle as clr_status SHALL be counted after the clear, so the counter becomes 1 and the flag becomes 1.
REQ-015 clr_status SHALL NOT affect the FSM, stage_bypass or cfg_busy.
REQ-016 All outputs except chain_valid_in SHALL be registered.

Reset
REQ-017 While rst_n is low, the following SHALL hold immediately and independently of clk:
- state = RUN;
- stage_bypass = 0, coeff_wr_en = 0;
- cfg_busy = 0, cfg_done = 0;
- overflow = 0, underflow = 0;
- ovf_cnt = 0, drop_cnt = 0;
- the quiet and flush counters = 0.
REQ-018 Reset during DRAIN, APPLY or FLUSH SHALL abandon the pending configuration with no coeff_wr_en pulse and no cfg_done pulse.
REQ-019 On the first clock edge after rst_n rises, chain_valid_in SHALL follow valid_in.

Structure
REQ-020 A shared package dfe_ctrl_pkg SHALL hold:
- the state enum (RUN, DRAIN, APPLY, FLUSH);
- default constants for N_STAGE, CNT_WIDTH, QUIET_CYCLES and FLUSH_CYCLES.
REQ-021 One sub-module, sat_counter (CNT_WIDTH, inc, clr), SHALL be instantiated N_STAGE+1 times: one per stage for ovf_cnt and one for drop_cnt.
REQ-022 The FSM and the hold gating SHALL reside in dfe_chain_ctrl.

Verification
REQ-023 Pass-through: in RUN, valid_in toggles 1/0 for 20 cycles -> chain_valid_in is identical to valid_in and drop_cnt = 0.
REQ-024 Reconfiguration:
- Stimulus: cfg_req with cfg_bypass=5'b00101 and mask=5'b00010; stage_valid is pulsed 3 cycles later; valid_in is held high throughout.
- Required response: APPLY occurs 8 quiet cycles after the last stage_valid; coeff_wr_en=00010 for exactly 1 cycle; cfg_done occurs 4 cycles after APPLY; drop_cnt equals the number of held cycles.
REQ-025 A second cfg_req during DRAIN -> it is ignored, and stage_bypass ends at the first request's vector.
REQ-026 Saturation:
- Stimulus: CNT_WIDTH=4, stage_ovf[2] held high for 20 cycles.
- Required response: ovf_cnt[2]=15, other counts 0, overflow=1.
REQ-027 clr_status coincident with a stage_unf[0] pulse -> underflow=1 and all counters 0; a later clr_status alone -> underflow=0.
REQ-028 rst_n asserted mid-FLUSH -> all outputs are 0 asynchronously, with no cfg_done and no coeff_wr_en.
